// File: rtl/lfsr_pkg.sv
// Shared definitions for the game-LFSR stream checker.
//   LFSR_W        : generator length (history depth kept by the checker)
//   TAP_A / TAP_B : history taps whose XOR predicts the next stream bit
//   state_e       : checker FSM states
//   lfsr_predict  : next-bit prediction from a history vector h[LFSR_W:1]
package lfsr_pkg;

  localparam int LFSR_W = 6;
  localparam int TAP_A  = 5;
  localparam int TAP_B  = 6;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // h[k] holds the stream bit k samples ago, so s[n] = h[5] ^ h[6].
  function automatic logic lfsr_predict(input logic [LFSR_W:1] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/lfsr_loss_window.sv
// Loss-of-lock detector for the stream checker.
// Counts valid bits in fixed windows of LOSS_WINDOW bits and the errors seen
// within the current window; flags loss when the LOSS_ERRS-th error of a
// window arrives.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   clr_i     : clear both counters (lock entry)
//   bit_en_i  : a valid bit is being checked this cycle (LOCKED only)
//   err_i     : that bit mismatched the prediction
//   loss_o    : combinational, high on the bit that completes LOSS_ERRS errors
module lfsr_loss_window #(
  parameter int LOSS_WINDOW = 32,
  parameter int LOSS_ERRS   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic bit_en_i,
  input  logic err_i,
  output logic loss_o
);

  localparam int WIN_W = (LOSS_WINDOW > 2) ? $clog2(LOSS_WINDOW) : 1;
  localparam int ERR_W = $clog2(LOSS_ERRS + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(LOSS_WINDOW - 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(LOSS_ERRS - 1);

  logic [WIN_W-1:0] wbit_q, wbit_d;
  logic [ERR_W-1:0] werr_q, werr_d;

  // The error on the last bit of a window still counts toward that window.
  assign loss_o = bit_en_i && err_i && (werr_q == ERR_LAST);

  always_comb begin
    wbit_d = wbit_q;
    werr_d = werr_q;
    if (clr_i) begin
      wbit_d = '0;
      werr_d = '0;
    end else if (bit_en_i) begin
      if (wbit_q == WIN_LAST) begin
        wbit_d = '0;
        werr_d = '0;
      end else begin
        wbit_d = wbit_q + WIN_W'(1);
        if (err_i) begin
          werr_d = werr_q + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbit_q <= '0;
      werr_q <= '0;
    end else begin
      wbit_q <= wbit_d;
      werr_q <= werr_d;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receiver-side checker for the game's 6-bit LFSR stream (s[n] = s[n-5]^s[n-6]).
// Self-synchronises to the incoming stream, declares lock, then counts bit
// errors against a free-running local copy.
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   in_valid    : in_bit is sampled on this edge
//   in_bit      : received stream bit
//   clear_count : synchronous clear of err_count (wins over an increment)
//   locked      : high while in LOCKED
//   err_pulse   : one-cycle pulse per mismatched bit while LOCKED
//   lock_lost   : one-cycle pulse on LOCKED -> SEARCH
//   err_count   : saturating error count
//
// state  | meaning
// FILL   | loading the first LFSR_W bits into the history
// SEARCH | history follows the input; counting consecutive correct predictions
// LOCKED | history free-runs on its own prediction; mismatches are errors
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES = 12,
  parameter int LOSS_ERRS    = 4,
  parameter int LOSS_WINDOW  = 32,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_count,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);

  state_e             state_q, state_d;
  logic [LFSR_W:1]    hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               err_pulse_q, err_pulse_d;
  logic               lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic pred;
  logic hist_zero;
  logic mismatch;
  logic win_clr;
  logic win_en;
  logic loss;

  assign pred      = lfsr_predict(hist_q);
  assign hist_zero = (hist_q == '0);
  assign mismatch  = (in_bit != pred);
  assign win_en    = in_valid && (state_q == LOCKED);

  lfsr_loss_window #(
    .LOSS_WINDOW (LOSS_WINDOW),
    .LOSS_ERRS   (LOSS_ERRS)
  ) u_loss_window (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (win_clr),
    .bit_en_i (win_en),
    .err_i    (mismatch),
    .loss_o   (loss)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_clr = 1'b0;
    if (in_valid) begin
      case (state_q)
        FILL: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_LAST) begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
          end
        end
        SEARCH: begin
          // An all-zero history is the LFSR lock-up state and never a match.
          if (!hist_zero && !mismatch) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              win_clr = 1'b1;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (loss) begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
          match_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    hist_d      = hist_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    err_count_d = err_count_q;
    if (in_valid) begin
      // Once locked the history is fed from its own prediction, so a corrupted
      // input bit never enters it and produces exactly one error.
      hist_d = {hist_q[LFSR_W-1:1], (state_q == LOCKED) ? pred : in_bit};
      if (state_q == LOCKED) begin
        err_pulse_d = mismatch;
        lock_lost_d = loss;
      end
    end
    if (clear_count) begin
      err_count_d = '0;
    end else if (err_pulse_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  localparam int LOCK_MATCHES = 12;

  logic clock       = 1'b0;
  logic reset       = 1'b0;
  logic in_valid    = 1'b0;
  logic in_bit      = 1'b0;
  logic clear_count = 1'b0;

  logic        locked_a, err_pulse_a, lock_lost_a;
  logic [15:0] err_count_a;
  logic        locked_b, err_pulse_b, lock_lost_b;
  logic [3:0]  err_count_b;

  always #5 clock = ~clock;

  lfsr_checker #(
    .LOCK_MATCHES (12),
    .LOSS_ERRS    (4),
    .LOSS_WINDOW  (32),
    .CNT_W        (16)
  ) u_dut_a (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked_a),
    .err_pulse   (err_pulse_a),
    .lock_lost   (lock_lost_a),
    .err_count   (err_count_a)
  );

  lfsr_checker #(
    .LOCK_MATCHES (12),
    .LOSS_ERRS    (4),
    .LOSS_WINDOW  (32),
    .CNT_W        (4)
  ) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked_b),
    .err_pulse   (err_pulse_b),
    .lock_lost   (lock_lost_b),
    .err_count   (err_count_b)
  );

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic        lost;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  typedef struct {
    string name;
    int    nbits;
    int    idle_every;
    int    err_first;
    int    err_num;
    int    err_step;
    bit    zeros;
    int    lock_bit;
    int    loss_bit;
    int    fin_a;
    int    fin_b;
    int    n_pulse;
    int    n_lost;
  } vec_t;

  exp_t  sb[$];
  vec_t  tbl[7];
  int    checks = 0;
  int    errors = 0;
  string cur_name;

  logic [5:0]  gen;
  int          vi;
  bit          exp_locked;
  logic [15:0] c_a;
  logic [3:0]  c_b;
  int          n_pulse_obs;
  int          n_lost_obs;

  task automatic check_val(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic clr, input exp_t e);
    exp_t x;
    exp_t got;
    in_valid    = v;
    in_bit      = b;
    clear_count = clr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    x   = sb.pop_front();
    got = {locked_a, err_pulse_a, lock_lost_a, err_count_a, err_count_b};
    checks++;
    if (got !== x || {locked_b, err_pulse_b, lock_lost_b} !== {x.locked, x.pulse, x.lost}) begin
      errors++;
      $display("FAIL %s cycle vbit=%0d: got locked=%0b/%0b pulse=%0b/%0b lost=%0b/%0b cnt=%0d/%0d expected locked=%0b pulse=%0b lost=%0b cnt=%0d/%0d",
               cur_name, vi, locked_a, locked_b, err_pulse_a, err_pulse_b, lock_lost_a, lock_lost_b,
               err_count_a, err_count_b, x.locked, x.pulse, x.lost, x.cnt_a, x.cnt_b);
    end
    if (err_pulse_a) n_pulse_obs++;
    if (lock_lost_a) n_lost_obs++;
    in_valid    = 1'b0;
    clear_count = 1'b0;
  endtask

  task automatic valid_bit(input bit zeros, input bit corrupt, input bit clr,
                           input int lock_bit, input int loss_bit);
    logic b;
    bit   pulse;
    bit   lost;
    exp_t e;
    vi++;
    b     = zeros ? 1'b0 : gen[5];
    gen   = {gen[4:0], gen[5] ^ gen[4]};
    pulse = corrupt && exp_locked;
    lost  = (loss_bit != 0) && (vi == loss_bit);
    if (pulse) begin
      if (c_a != 16'hFFFF) c_a = c_a + 16'd1;
      if (c_b != 4'hF)     c_b = c_b + 4'd1;
    end
    if (clr) begin
      c_a = '0;
      c_b = '0;
    end
    if (vi == lock_bit || (loss_bit != 0 && vi == loss_bit + LOCK_MATCHES)) exp_locked = 1'b1;
    if (lost) exp_locked = 1'b0;
    e = {exp_locked, pulse, lost, c_a, c_b};
    step(1'b1, b ^ corrupt, clr, e);
  endtask

  task automatic idle_cycle();
    exp_t e;
    e = {exp_locked, 1'b0, 1'b0, c_a, c_b};
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, e);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int k;
    bit corrupt;
    cur_name    = v.name;
    in_valid    = 1'b0;
    clear_count = 1'b0;
    reset       = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({locked_a, err_pulse_a, lock_lost_a, err_count_a, locked_b, err_pulse_b, lock_lost_b, err_count_b} !== '0) begin
      errors++;
      $display("FAIL %s reset state: got locked=%0b pulse=%0b lost=%0b cnt=%0d/%0d expected all 0",
               v.name, locked_a, err_pulse_a, lock_lost_a, err_count_a, err_count_b);
    end
    reset       = 1'b1;
    gen         = 6'b000001;
    vi          = 0;
    exp_locked  = 1'b0;
    c_a         = '0;
    c_b         = '0;
    n_pulse_obs = 0;
    n_lost_obs  = 0;
    cyc         = 0;
    while (vi < v.nbits) begin
      cyc++;
      if (v.idle_every > 0 && (cyc % v.idle_every) == 0) begin
        idle_cycle();
      end else begin
        k       = vi + 1 - v.err_first;
        corrupt = (v.err_num > 0) && (k >= 0) && ((k % v.err_step) == 0) && ((k / v.err_step) < v.err_num);
        valid_bit(v.zeros, corrupt, 1'b0, v.lock_bit, v.loss_bit);
      end
    end
    check_val({v.name, " err_count cnt16"}, int'(err_count_a), v.fin_a);
    check_val({v.name, " err_count cnt4"},  int'(err_count_b), v.fin_b);
    check_val({v.name, " err_pulse count"}, n_pulse_obs, v.n_pulse);
    check_val({v.name, " lock_lost count"}, n_lost_obs,  v.n_lost);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          name      bits idle first num step zeros lock loss fin_a fin_b pulses lost
    tbl[0] = '{"clean",   200, 0,   0,    0,  1,   1'b0, 18,  0,   0,    0,    0,     0};
    tbl[1] = '{"idle",     60, 3,   0,    0,  1,   1'b0, 18,  0,   0,    0,    0,     0};
    tbl[2] = '{"single",   80, 0,   40,   1,  1,   1'b0, 18,  0,   1,    1,    1,     0};
    tbl[3] = '{"burst",    80, 0,   40,   4,  2,   1'b0, 18,  46,  4,    4,    4,     1};
    tbl[4] = '{"zeros",    40, 0,   0,    0,  1,   1'b1, 0,   0,   0,    0,    0,     0};
    tbl[5] = '{"sat",     235, 0,   20,   20, 11,  1'b0, 18,  0,   20,   15,   20,    0};
    tbl[6] = '{"relock",   30, 0,   0,    0,  1,   1'b0, 18,  0,   0,    0,    0,     0};

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i]);
    end

    // Continue the saturated run: clear_count coincides with an error.
    cur_name = "clear_vs_err";
    repeat (4) valid_bit(1'b0, 1'b0, 1'b0, 0, 0);
    valid_bit(1'b0, 1'b1, 1'b1, 0, 0);
    check_val("clear_vs_err err_pulse", int'(err_pulse_a), 1);
    check_val("clear_vs_err err_count", int'(err_count_a), 0);
    check_val("clear_vs_err locked",    int'(locked_b),    1);

    // Reset asserted between edges while locked with err_pulse high.
    cur_name = "async_reset";
    repeat (4) valid_bit(1'b0, 1'b0, 1'b0, 0, 0);
    valid_bit(1'b0, 1'b1, 1'b0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_reset locked",    int'(locked_a),    0);
    check_val("async_reset err_pulse", int'(err_pulse_a), 0);
    check_val("async_reset err_count", int'(err_count_a), 0);
    check_val("async_reset cnt4",      int'(err_count_b), 0);
    @(posedge clock);
    #1;
    run_vec(tbl[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
